any1_tlb_walker: RTL and testbench

- Hardware TLB refill controller for the ANY-1 4-way, 1024-set TLB.
- On a TLB miss it fetches the 64-bit PTE from a single-level page table over a Wishbone-style master port. It builds a TLB entry, selects a way round-robin, and writes the entry through the TLB write port.
- It also arbitrates that write port between the walker and software CSR writes.
- Sits between the TLB, the MMU CSRs (PTBR, ASID) and the data-side bus arbiter.

---
 rtl/any1_tlb_walker_if.sv | 23 ++
 rtl/any1_tlb_walker.sv | 173 +++++++++++++++++
 tb/tb_any1_tlb_walker.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/any1_tlb_walker_if.sv
// Data-side bus port of the ANY-1 TLB walker: one 64-bit read per page walk.
// Member names are given from the walker's point of view.
interface any1_tlb_walker_if #(
  parameter int unsigned AWID = 32
) ();
  logic            cyc_o;
  logic            stb_o;
  logic [AWID-1:0] adr_o;
  logic            ack_i;
  logic [63:0]     dat_i;

  // Walker side
  modport master (
    output cyc_o, stb_o, adr_o,
    input  ack_i, dat_i
  );

  // Bus arbiter / memory side
  modport slave (
    input  cyc_o, stb_o, adr_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/any1_tlb_walker.sv
// ANY-1 TLB refill controller for the 4-way, 1024-set TLB.
// On a miss it reads one PTE from a single-level page table and builds a TLB
// entry. It writes the entry into a round-robin way. It also shares the TLB
// write port with software CSR writes.
// Optional feature: define ANY1_TLBW_TIMEOUT_EN to abandon a walk whose bus
// read is not acknowledged within TIMEOUT cycles. The walk then reports a
// page fault.
module any1_tlb_walker #(
  parameter int unsigned AWID    = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            miss_i,
  input  logic [AWID-1:0] miss_adr_i,
  input  logic [7:0]      asid_i,
  input  logic [AWID-1:0] ptbr_i,
  input  logic            sw_wr_i,
  input  logic [11:0]     sw_adr_i,
  input  logic [63:0]     sw_dat_i,
  output logic            sw_rdy_o,
  any1_tlb_walker_if.master bus,
  output logic            tlben_o,
  output logic            wrtlb_o,
  output logic [11:0]     tlbadr_o,
  output logic [63:0]     tlbdat_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            fault_o,
  output logic [AWID-1:0] fault_adr_o
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WRITE,
    HOLD,
    FAULT
  } state_t;

  state_t          state_q;
  logic [AWID-1:0] vadr_q;
  logic [7:0]      asid_q;
  logic [1:0]      way_q;
  logic [1:0]      hold_q;
  logic            cyc_q;
  logic            busy_q;
  logic            wrtlb_q;
  logic            done_q;
  logic            fault_q;
  logic [AWID-1:0] fault_adr_q;
  logic [11:0]     tlbadr_q;
  logic [63:0]     tlbdat_q;
`ifdef ANY1_TLBW_TIMEOUT_EN
  logic [7:0]      tmo_q;
`endif

  logic [AWID-1:0] pte_off;
  logic [11:0]     tlbadr_d;
  logic [63:0]     tlbdat_d;
  logic            sw_take;
  logic            unused_pte;

  // PTE address: one 8-byte PTE per 16 KiB page. It follows ptbr_i live.
  assign pte_off = AWID'({vadr_q[AWID-1:14], 3'b000});

  // TLB entry assembled straight from the bus data on the ack cycle
  assign tlbadr_d = {way_q, vadr_q[23:14]};
  assign tlbdat_d = {asid_q, bus.dat_i[62], 1'b0, 1'b0, 1'b0, bus.dat_i[51:48],
                     16'(vadr_q[AWID-1:24]), 32'(bus.dat_i[AWID-15:0])};
  assign unused_pte = ^{bus.dat_i[61:52], bus.dat_i[47:AWID-14]};

  // Software writes pass through combinationally in IDLE.
  // sw_rdy_o and the write strobe then appear in the same cycle as the request.
  assign sw_take  = (state_q == IDLE) && sw_wr_i;
  assign sw_rdy_o = sw_take;
  assign wrtlb_o  = sw_take | wrtlb_q;
  assign tlben_o  = sw_take | wrtlb_q;
  assign tlbadr_o = sw_take ? sw_adr_i : tlbadr_q;
  assign tlbdat_o = sw_take ? sw_dat_i : tlbdat_q;

  assign bus.cyc_o   = cyc_q;
  assign bus.stb_o   = cyc_q;
  assign bus.adr_o   = cyc_q ? (ptbr_i + pte_off) : '0;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign fault_o     = fault_q;
  assign fault_adr_o = fault_adr_q;

  // Walk FSM with registered outputs; reset drops the bus cycle immediately
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      vadr_q      <= '0;
      asid_q      <= '0;
      way_q       <= '0;
      hold_q      <= '0;
      cyc_q       <= 1'b0;
      busy_q      <= 1'b0;
      wrtlb_q     <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fault_adr_q <= '0;
      tlbadr_q    <= '0;
      tlbdat_q    <= '0;
`ifdef ANY1_TLBW_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_q != 2'd0) hold_q <= hold_q - 2'd1;
          if (!sw_wr_i && miss_i && (hold_q == 2'd0)) begin
            vadr_q  <= miss_adr_i;
            asid_q  <= asid_i;
            cyc_q   <= 1'b1;
            busy_q  <= 1'b1;
`ifdef ANY1_TLBW_TIMEOUT_EN
            tmo_q   <= '0;
`endif
            state_q <= REQ;
          end
        end
        REQ: begin
          // ack takes precedence over a timeout that expires in the same cycle
          if (bus.ack_i) begin
            cyc_q <= 1'b0;
            if (bus.dat_i[63]) begin
              wrtlb_q  <= 1'b1;
              done_q   <= 1'b1;
              tlbadr_q <= tlbadr_d;
              tlbdat_q <= tlbdat_d;
              state_q  <= WRITE;
            end else begin
              fault_q     <= 1'b1;
              fault_adr_q <= vadr_q;
              state_q     <= FAULT;
            end
          end
`ifdef ANY1_TLBW_TIMEOUT_EN
          else if (tmo_q == 8'(TIMEOUT - 1)) begin
            cyc_q       <= 1'b0;
            fault_q     <= 1'b1;
            fault_adr_q <= vadr_q;
            state_q     <= FAULT;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`endif
        end
        WRITE: begin
          wrtlb_q <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          way_q   <= way_q + 2'd1;
          state_q <= HOLD;
        end
        FAULT: begin
          fault_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= HOLD;
        end
        HOLD: begin
          // Gives the TLB two cycles to withdraw the miss that was just serviced
          hold_q  <= 2'd2;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_any1_tlb_walker.sv
// Self-checking bench for any1_tlb_walker: table of directed refills plus
// hand-written sequences for arbitration, hold-off, timeout and reset.
module tb_any1_tlb_walker;
  localparam int unsigned AWID = 32;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic            miss_i = 1'b0;
  logic [AWID-1:0] miss_adr_i = '0;
  logic [7:0]      asid_i = '0;
  logic [AWID-1:0] ptbr_i = '0;
  logic            sw_wr_i = 1'b0;
  logic [11:0]     sw_adr_i = '0;
  logic [63:0]     sw_dat_i = '0;
  logic            sw_rdy_o;
  logic            tlben_o, wrtlb_o, busy_o, done_o, fault_o;
  logic [11:0]     tlbadr_o;
  logic [63:0]     tlbdat_o;
  logic [AWID-1:0] fault_adr_o;

  any1_tlb_walker_if #(.AWID(AWID)) bus ();

  any1_tlb_walker #(.AWID(AWID), .TIMEOUT(255)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .miss_i(miss_i), .miss_adr_i(miss_adr_i),
    .asid_i(asid_i), .ptbr_i(ptbr_i), .sw_wr_i(sw_wr_i), .sw_adr_i(sw_adr_i),
    .sw_dat_i(sw_dat_i), .sw_rdy_o(sw_rdy_o), .bus(bus), .tlben_o(tlben_o),
    .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o),
    .busy_o(busy_o), .done_o(done_o), .fault_o(fault_o),
    .fault_adr_o(fault_adr_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vadr;
    logic [31:0] ptbr;
    logic [7:0]  asid;
    logic [63:0] pte;
    bit          flt;
    logic [31:0] exp_adr;
    logic [9:0]  set;
    logic [63:0] exp_dat;
    int unsigned lat;
  } vec_t;

  vec_t       vec[6];
  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_way = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (3) tick();
  endtask

  // Raise a miss and wait (bounded) for the bus request
  task automatic start_walk(input int i, input bit keep);
    bit seen;
    seen = 1'b0;
    miss_i     = 1'b1;
    miss_adr_i = vec[i].vadr;
    ptbr_i     = vec[i].ptbr;
    asid_i     = vec[i].asid;
    for (int n = 0; n < 8 && !seen; n++) begin
      tick();
      seen = bus.cyc_o;
    end
    chk("cyc_rise", 64'(seen), 64'd1);
    chk("req_adr", 64'(bus.adr_o), 64'(vec[i].exp_adr));
    chk("req_stb", 64'(bus.stb_o), 64'd1);
    chk("req_busy", 64'(busy_o), 64'd1);
    if (!keep) miss_i = 1'b0;
  endtask

  // Acknowledge after lat cycles, then check WRITE/FAULT and HOLD
  task automatic finish_walk(input int i, input int unsigned lat);
    repeat (lat) tick();
    bus.ack_i = 1'b1;
    bus.dat_i = vec[i].pte;
    tick();
    bus.ack_i = 1'b0;
    bus.dat_i = '0;
    chk("cyc_drop", 64'(bus.cyc_o), 64'd0);
    chk("sw_rdy_in_walk", 64'(sw_rdy_o), 64'd0);
    if (!vec[i].flt) begin
      chk("wr_strobe", 64'({wrtlb_o, tlben_o, done_o, fault_o}), 64'b1110);
      chk("wr_tlbadr", 64'(tlbadr_o), 64'({exp_way, vec[i].set}));
      chk("wr_tlbdat", tlbdat_o, vec[i].exp_dat);
      exp_way = exp_way + 2'd1;
    end else begin
      chk("flt_strobe", 64'({wrtlb_o, done_o, fault_o, busy_o}), 64'b0011);
      chk("flt_adr", 64'(fault_adr_o), 64'(vec[i].vadr));
    end
    tick();
    chk("hold_quiet", 64'({wrtlb_o, done_o, fault_o, busy_o, sw_rdy_o}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stuck;
    int n;
    int bad;

    //           vadr          ptbr          asid   pte                    flt   exp_adr       set     exp_dat                lat
    vec[0] = '{32'h12345678, 32'h00100000, 8'h05, 64'h8003_0000_0000_0ABC, 1'b0, 32'h00124688, 10'h0D1, 64'h0503_0012_0000_0ABC, 3};
    vec[1] = '{32'hFFFFC000, 32'h00001000, 8'hA5, 64'hC3AF_1234_FFFF_FFFF, 1'b0, 32'h00200FF8, 10'h3FF, 64'hA58F_00FF_0003_FFFF, 0};
    vec[2] = '{32'h00004000, 32'hFFFFFFF8, 8'h00, 64'h8000_0000_0000_0000, 1'b0, 32'h00000000, 10'h001, 64'h0000_0000_0000_0000, 1};
    vec[3] = '{32'h00ABCDEF, 32'h00400000, 8'h3C, 64'hA005_0000_0001_2345, 1'b0, 32'h00401578, 10'h2AF, 64'h3C05_0000_0001_2345, 2};
    vec[4] = '{32'h0BADC000, 32'h00100000, 8'h11, 64'h0000_0000_0000_0001, 1'b1, 32'h001175B8, 10'h2B7, 64'h0,                   1};
    vec[5] = '{32'h00004000, 32'h00000000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h00000008, 10'h001, 64'hFF8F_0000_0003_FFFF, 0};

    bus.ack_i = 1'b0;
    bus.dat_i = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs", 64'({bus.cyc_o, bus.stb_o, busy_o, done_o, fault_o, wrtlb_o, tlben_o, sw_rdy_o}), 64'd0);
    chk("rst_fault_adr", 64'(fault_adr_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // Table: ways 0..3, invalid PTE (way kept), then way 0 again
    for (int i = 0; i < 6; i++) begin
      start_walk(i, 1'b0);
      finish_walk(i, vec[i].lat);
      settle();
    end

    // Software write and miss in the same idle cycle
    sw_wr_i  = 1'b1;
    sw_adr_i = 12'hABC;
    sw_dat_i = 64'hDEAD_BEEF_0123_4567;
    miss_i     = 1'b1;
    miss_adr_i = vec[1].vadr;
    ptbr_i     = vec[1].ptbr;
    asid_i     = vec[1].asid;
    #1;
    chk("arb_sw_first", 64'({sw_rdy_o, wrtlb_o, tlben_o, bus.cyc_o}), 64'b1110);
    chk("arb_sw_adr", 64'(tlbadr_o), 64'h0ABC);
    chk("arb_sw_dat", tlbdat_o, 64'hDEAD_BEEF_0123_4567);
    tick();
    sw_wr_i = 1'b0;
    chk("arb_no_req_yet", 64'(bus.cyc_o), 64'd0);
    tick();
    chk("arb_req_next", 64'(bus.cyc_o), 64'd1);
    chk("arb_req_adr", 64'(bus.adr_o), 64'(vec[1].exp_adr));
    miss_i = 1'b0;
    finish_walk(1, 1);
    settle();

    // Software write held through a whole walk
    start_walk(3, 1'b0);
    sw_wr_i  = 1'b1;
    sw_adr_i = 12'h5A5;
    sw_dat_i = 64'h1122_3344_5566_7788;
    #1;
    chk("sw_blocked_req", 64'(sw_rdy_o), 64'd0);
    finish_walk(3, 1);
    tick();
    chk("sw_after_walk", 64'({sw_rdy_o, wrtlb_o}), 64'b11);
    chk("sw_after_adr", 64'(tlbadr_o), 64'h5A5);
    chk("sw_after_dat", tlbdat_o, 64'h1122_3344_5566_7788);
    tick();
    sw_wr_i = 1'b0;
    #1;
    chk("sw_single", 64'(sw_rdy_o), 64'd0);
    settle();

    // Miss held high across a refill: hold-off before the next request
    start_walk(0, 1'b1);
    finish_walk(0, 0);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.cyc_o) bad++;
    end
    chk("hold_off", 64'(bad), 64'd0);
    tick();
    chk("hold_release", 64'(bus.cyc_o), 64'd1);
    chk("hold_req_adr", 64'(bus.adr_o), 64'(vec[0].exp_adr));
    miss_i = 1'b0;
    finish_walk(0, 2);
    settle();

`ifdef ANY1_TLBW_TIMEOUT_EN
    // No ack: fault after TIMEOUT cycles in REQ
    start_walk(0, 1'b0);
    n = 0;
    while (n < 400 && !fault_o) begin
      tick();
      n++;
    end
    chk("tmo_cycles", 64'(n), 64'd255);
    chk("tmo_fault", 64'({fault_o, wrtlb_o, bus.cyc_o}), 64'b100);
    chk("tmo_fault_adr", 64'(fault_adr_o), 64'(vec[0].vadr));
    tick();
    settle();
`else
    // No ack: the request is held indefinitely
    start_walk(4, 1'b0);
    stuck = 0;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (!bus.cyc_o) stuck++;
    end
    chk("no_tmo_wait", 64'(stuck), 64'd0);
    finish_walk(4, 0);
    settle();
`endif

    // Reset during REQ: bus drops at once, no write, way counter back to 0
    start_walk(1, 1'b0);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_async", 64'({bus.cyc_o, bus.stb_o, busy_o}), 64'd0);
    chk("rst_adr", 64'(bus.adr_o), 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    bus.ack_i = 1'b1;
    bus.dat_i = vec[1].pte;
    tick();
    bus.ack_i = 1'b0;
    bus.dat_i = '0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      if (wrtlb_o || done_o || bus.cyc_o) bad++;
      tick();
    end
    chk("rst_no_write", 64'(bad), 64'd0);
    exp_way = 2'd0;
    start_walk(0, 1'b0);
    finish_walk(0, 1);
    settle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
